// File: rtl/unidade_de_busca.sv
// unidade_de_busca: two-word instruction fetch/sequencing FSM; FETCH_HALT_EN enables the HLT/HALT state
module unidade_de_busca #(
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [8:0]        mem_data,
  input  logic              branch_select,
  input  logic              bus_zero,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [1:0]        counter,
  output logic [8:0]        iin,
  output logic [8:0]        imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  typedef enum logic [2:0] {F0, F1, F2, F3, E1, E2, E3, HALT} state_t;
  state_t state, state_nx;
  // state register
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= F0;
    else state <= state_nx;
  // opcode/immediate capture and end-of-instruction pc update
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      pc  <= '0;
      iin <= '0;
      imm <= '0;
    end else begin
      if (state == F1) iin <= mem_data;
      if (state == F2) imm <= mem_data;
      if (state == E3) pc <= (branch_select && bus_zero) ? imm[ADDR_W-1:0] : pc + ADDR_W'(2);
    end
  // next-state and phase/ROM decode
  always_comb begin
    state_nx  = F0;
    mem_rd_en = (state == F0) || (state == F1);
    mem_addr  = (state == F1) ? pc + ADDR_W'(1) : pc;
    counter   = (state == E1) ? 2'b01 : (state == E2) ? 2'b10 : (state == E3) ? 2'b11 : 2'b00;
    halted    = 1'b0;
    case (state)
      F0: state_nx = F1;
      F1: state_nx = F2;
      F2: state_nx = F3;
      F3: state_nx = E1;
`ifdef FETCH_HALT_EN
      E1: state_nx = (iin[8:6] == 3'b011) ? HALT : E2;
      HALT: begin
        state_nx = HALT;
        counter  = 2'b01;
        halted   = 1'b1;
      end
`else
      E1: state_nx = E2;
`endif
      E2: state_nx = E3;
      default: state_nx = F0;
    endcase
  end
endmodule

// File: tb/tb_unidade_de_busca.sv
// tb_unidade_de_busca: directed self-checking bench for unidade_de_busca
module tb_unidade_de_busca;
  logic       clock, resetn, branch_select, bus_zero, mem_rd_en, halted;
  logic [8:0] mem_data, iin, imm;
  logic [7:0] mem_addr, pc;
  logic [1:0] counter;
  logic [8:0] rom [256];
  int n_chk, n_fail;

  unidade_de_busca #(.ADDR_W(8)) dut (
    .clock(clock), .resetn(resetn), .mem_data(mem_data), .branch_select(branch_select),
    .bus_zero(bus_zero), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .counter(counter),
    .iin(iin), .imm(imm), .pc(pc), .halted(halted)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) if (mem_rd_en) mem_data <= rom[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [7:0] p, input logic [8:0] ei, input logic [8:0] em,
                       input logic bs, input logic bz);
    logic [7:0] p1;
    p1 = p + 8'd1;
    chk("f0_addr", mem_addr, p);
    chk("f0_rd", mem_rd_en, 1);
    chk("f0_cnt", counter, 0);
    chk("f0_pc", pc, p);
    @(negedge clock);
    chk("f1_addr", mem_addr, p1);
    chk("f1_rd", mem_rd_en, 1);
    chk("f1_cnt", counter, 0);
    @(negedge clock);
    chk("f2_iin", iin, ei);
    chk("f2_rd", mem_rd_en, 0);
    chk("f2_cnt", counter, 0);
    @(negedge clock);
    chk("f3_imm", imm, em);
    chk("f3_cnt", counter, 0);
    @(negedge clock);
    chk("e1_cnt", counter, 1);
    @(negedge clock);
    chk("e2_cnt", counter, 2);
    chk("e2_halted", halted, 0);
    @(negedge clock);
    chk("e3_cnt", counter, 3);
    chk("e3_pc", pc, p);
    branch_select = bs;
    bus_zero = bz;
    @(negedge clock);
    branch_select = 0;
    bus_zero = 0;
  endtask

  task automatic program_to_6();
    instr(8'd0, 9'o012, 9'd5, 0, 0);
    instr(8'd2, 9'o500, 9'd20, 1, 1);
    instr(8'd20, 9'o500, 9'd40, 1, 0);
    instr(8'd22, 9'o500, 9'd255, 1, 1);
    instr(8'd255, 9'o111, 9'o012, 0, 0);
    instr(8'd1, 9'd5, 9'o500, 0, 0);
    instr(8'd3, 9'd20, 9'd6, 1, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0] = 9'o012; rom[1] = 9'd5;
    rom[2] = 9'o500; rom[3] = 9'd20; rom[4] = 9'd6;
    rom[6] = 9'o300; rom[7] = 9'd0;
    rom[20] = 9'o500; rom[21] = 9'd40;
    rom[22] = 9'o500; rom[23] = 9'd255;
    rom[255] = 9'o111;
    mem_data = 0;
    branch_select = 0;
    bus_zero = 0;
    resetn = 0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_pc", pc, 0);
    chk("rst_iin", iin, 0);
    chk("rst_imm", imm, 0);
    chk("rst_cnt", counter, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd_en, 1);
    chk("rst_halted", halted, 0);
    resetn = 1;
    program_to_6();
    @(negedge clock);
    @(negedge clock);
    chk("midf2_pc", pc, 6);
    chk("midf2_iin", iin, 9'o300);
    #2 resetn = 0;
    #1;
    chk("midf2_rst_pc", pc, 0);
    chk("midf2_rst_cnt", counter, 0);
    chk("midf2_rst_iin", iin, 0);
    chk("midf2_rst_imm", imm, 0);
    chk("midf2_rst_addr", mem_addr, 0);
    @(negedge clock);
    resetn = 1;
    program_to_6();
`ifdef FETCH_HALT_EN
    @(negedge clock);
    @(negedge clock);
    chk("hlt_iin", iin, 9'o300);
    @(negedge clock);
    @(negedge clock);
    chk("hlt_e1_cnt", counter, 1);
    chk("hlt_e1_halted", halted, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("halt_halted", halted, 1);
      chk("halt_cnt", counter, 1);
      chk("halt_rd", mem_rd_en, 0);
      chk("halt_pc", pc, 6);
    end
`else
    instr(8'd6, 9'o300, 9'd0, 0, 0);
    chk("nohlt_pc", pc, 8);
    chk("nohlt_halted", halted, 0);
    chk("nohlt_addr", mem_addr, 8);
`endif
    #2 resetn = 0;
    #1;
    chk("hrst_halted", halted, 0);
    chk("hrst_pc", pc, 0);
    chk("hrst_cnt", counter, 0);
    chk("hrst_rd", mem_rd_en, 1);
    @(negedge clock);
    resetn = 1;
    instr(8'd0, 9'o012, 9'd5, 0, 0);
    chk("resume_addr", mem_addr, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unidade_de_busca.md
# unidade_de_busca

Instruction fetch and sequencing unit for the 9-bit processor. It reads two-word instructions from a synchronous program ROM, holding the opcode word and the immediate word in registers. It drives the 2-bit phase `counter` and the `iin` word consumed by `logica_de_controle`, and it updates the PC at the end of each instruction, including the BEZ branch.

## Interface
- `ADDR_W`, default 8: program address width; legal range 1..9. The branch target is `imm[ADDR_W-1:0]`.
- `clock`  in  1  — the single clock; all state updates on its rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `mem_data`  in  9  — ROM read data, valid the cycle after `mem_rd_en`=1.
- `branch_select`  in  1  — from control; 1 when the current opcode is BEZ.
- `bus_zero`  in  1  — 1 when the datapath bus equals 0; sampled only in E3.
- `mem_addr`  out  ADDR_W  — ROM address.
- `mem_rd_en`  out  1  — ROM read strobe.
- `counter`  out  2  — phase presented to control.
- `iin`  out  9  — instruction register `{opcode[8:6], rx[5:3], ry[2:0]}`.
- `imm`  out  9  — immediate register.
- `pc`  out  ADDR_W  — address of the current instruction's opcode word.
- `halted`  out  1  — 1 after HLT has executed.

## Operation
- Each instruction occupies two words: the opcode word at `pc` and the immediate word at `pc+1`. Every instruction carries an immediate word, even when it is unused.
- The FSM has the states F0, F1, F2, F3, E1, E2, E3 and HALT. Transitions run in the order F0→F1→F2→F3→E1→E2→E3→F0.
- **F0:** `mem_addr`=`pc`, `mem_rd_en`=1, `counter`=00.
- **F1:** `mem_addr`=`pc+1` (wraps mod 2^ADDR_W), `mem_rd_en`=1, `counter`=00. `iin`←`mem_data` at the end of the cycle.
- **F2:** `mem_rd_en`=0, `counter`=00. `imm`←`mem_data` at the end of the cycle.
- **F3:** `counter`=00; `iin` and `imm` are stable, so the control logic's immediate register latches `imm` here.
- **E1:** `counter`=01.
- **E2:** `counter`=10.
- **E3:** `counter`=11. At the end of the cycle:
  - `pc` ← `imm[ADDR_W-1:0]` if `branch_select` & `bus_zero`;
  - otherwise `pc` ← `pc+2` mod 2^ADDR_W.
- **HLT:** in E1, if `iin[8:6]`=011 the next state is HALT (see Configuration).
- **HALT:**
  - `counter` holds 01, `mem_rd_en`=0, `halted`=1;
  - `pc`, `iin` and `imm` are frozen;
  - HALT is left only by reset.
- `iin` and `imm` change only at the end of F1 and F2.
- `mem_addr` and `mem_rd_en` are decoded from the state and `pc`.
- Any target address is legal, odd addresses included. No alignment is checked.

## Timing
- Reset (asynchronous, immediate on `resetn`=0):
  - state=F0, `pc`=0, `iin`=0, `imm`=0, `halted`=0;
  - `counter`=00, `mem_addr`=0, `mem_rd_en`=1 (F0 decode; ROM reads are side-effect free).
- After the first rising edge with `resetn`=1, the unit is in F1.
- Instruction period is 7 cycles. `counter` sequence: 00,00,00,00,01,10,11.
- `iin` is valid from the first cycle of F2, i.e. 2 cycles before `counter`=01. `imm` is valid from F3, i.e. 1 cycle before `counter`=01.
- The branch decision uses `branch_select` and `bus_zero` as sampled on the E3→F0 edge. The new `pc` is on `mem_addr` in the following F0.
- Wrap: with `pc`=2^ADDR_W−1, F1 reads address 0 and the next sequential `pc` is 1.
- Reset asserted mid-instruction, in any state including HALT: return to reset values immediately. No partial `pc` update occurs.
- `branch_select`=1 with `bus_zero`=0: sequential `pc+2`.

## Configuration
- Macro `FETCH_HALT_EN` controls HLT handling.
- Defined: opcode 011 in E1 enters HALT as described above.
- Undefined:
  - the HALT state is not implemented and `halted` is tied to 0;
  - opcode 011 sequences as a normal instruction through E3 with `pc`+2.

## Test plan
- **Reset mid-F2:** assert reset mid-F2 with `pc`=6 → `pc`=0, `counter`=00, `iin`=0, `imm`=0 immediately; after release, `mem_addr` shows 0 then 1.
- **Sequential fetch:** ROM[0]=9'o012, ROM[1]=9'd5, `branch_select`=0 → `iin`=9'o012 at F2, `imm`=5 at F3; `counter` runs 00×4,01,10,11; next `mem_addr`=2.
- **BEZ taken:** ROM[2]=BEZ, ROM[3]=9'd20, `branch_select`=1, `bus_zero`=1 in E3 → next F0 `mem_addr`=20. The same with `bus_zero`=0 → `mem_addr`=4.
- **Wrap:** ADDR_W=8, `pc`=255 → F1 `mem_addr`=0; next `pc`=1.
- **HLT with macro:** ROM word 9'o300 with `FETCH_HALT_EN` defined → `halted`=1 one cycle after `counter`=01; `counter` stays 01 and `mem_rd_en`=0 for 20 cycles. Without the macro → `halted`=0 and `pc` advances by 2.
- **Reset during HALT:** pulse `resetn` in HALT → `halted`=0, `pc`=0, fetching resumes from address 0.
